// File: rtl/dds_cfg_master.sv
// dds_cfg_master
// Register-write initiator for the DDS configuration bus. Parses framed
// command bytes (0xA5, ADDR_H, ADDR_L, DATA_H, DATA_L [, CSUM]) from a byte
// stream and issues a one-cycle write on wr/waddr/wdata, followed by one
// bus-idle cycle with address and data cleared.
//
// Optional feature macro: DDS_CFG_CHECKSUM_EN
//   defined   : frame carries a sixth byte CSUM = ADDR_H^ADDR_L^DATA_H^DATA_L;
//               a mismatch pulses err and drops the frame.
//   undefined : five-byte frames, DATA_L goes straight to WRITE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   rx_data    in   8-bit command byte
//   rx_valid   in   rx_data holds a byte
//   rx_ready   out  block can take a byte (IDLE and collection states)
//   wr         out  one-cycle register write strobe
//   waddr      out  write address, 0 when wr=0
//   wdata      out  write data, 0 when wr=0
//   busy       out  frame in progress (state not IDLE)
//   err        out  one-cycle pulse: bad header, timeout or checksum error
//   frame_cnt  out  completed writes, wraps 255 -> 0
//   dbg_state  out  current FSM state encoding
//
// Handshake: a byte transfers on a rising edge where rx_valid & rx_ready are
// both 1. rx_ready never depends on rx_valid; the source holds rx_data
// stable while rx_valid=1 and rx_ready=0.

module dds_cfg_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              err,
  output logic [7:0]        frame_cnt,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_H = 3'd1,
    S_ADDR_L = 3'd2,
    S_DATA_H = 3'd3,
    S_DATA_L = 3'd4,
`ifdef DDS_CFG_CHECKSUM_EN
    S_CSUM   = 3'd5,
`endif
    S_WRITE  = 3'd6,
    S_GAP    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        ah_q, ah_d, al_q, al_d, dh_q, dh_d, dl_q, dl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              accept;
  logic              collecting;

  assign accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d     = state_q;
    ah_d        = ah_q;
    al_d        = al_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    wr_d        = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;
    frame_cnt_d = frame_cnt_q;
    collecting  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (rx_data == HDR) state_d = S_ADDR_H;
          else                err_d   = 1'b1;
        end
      end
      S_WRITE: begin
        state_d     = S_GAP;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: collecting = 1'b1;
    endcase

    if (collecting) begin
      if (accept) begin
        cnt_d = '0;
        case (state_q)
          S_ADDR_H: begin ah_d = rx_data; state_d = S_ADDR_L; end
          S_ADDR_L: begin al_d = rx_data; state_d = S_DATA_H; end
          S_DATA_H: begin dh_d = rx_data; state_d = S_DATA_L; end
`ifdef DDS_CFG_CHECKSUM_EN
          S_DATA_L: begin dl_d = rx_data; state_d = S_CSUM; end
          S_CSUM: begin
            if (rx_data == (ah_q ^ al_q ^ dh_q ^ dl_q)) begin
              state_d = S_WRITE;
              wr_d    = 1'b1;
              waddr_d = ADDR_W'({ah_q, al_q});
              wdata_d = DATA_W'({dh_q, dl_q});
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
`else
          S_DATA_L: begin
            // Output registers load straight from the incoming byte so the
            // strobe appears in the cycle right after the last byte.
            dl_d    = rx_data;
            state_d = S_WRITE;
            wr_d    = 1'b1;
            waddr_d = ADDR_W'({ah_q, al_q});
            wdata_d = DATA_W'({dh_q, rx_data});
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end else if (cnt_q == CNT_W'(TIMEOUT)) begin
        // Partial frame abandoned; shadow bytes stay but are overwritten
        // by the next frame before any use.
        state_d = S_IDLE;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    rx_ready_d = (state_d != S_WRITE) && (state_d != S_GAP);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ah_q        <= '0;
      al_q        <= '0;
      dh_q        <= '0;
      dl_q        <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b1;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ah_q        <= ah_d;
      al_q        <= al_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign wr        = wr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule
